seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
- Parametrised, runtime-programmable serial pattern detector. Next generation of the team's fixed Mealy sequence detectors.
- Watches a qualified serial bit stream for a loadable PAT_W-bit pattern. Supports overlapping and non-overlapping modes.
- Counts matches and can enter a sticky LOCKED state after a configurable number of matches.
- Sits in the lab FSM datapath between the bit source and downstream status logic.

Parameters:
- PAT_W, 4, pattern length in bits; must be >= 2.
- CNT_W, 8, width of the match counter.
- LOCK_N, 0, match count that forces LOCKED; 0 disables locking; must be <= 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled only when high.
- load  input  1  captures pattern, clears history/count, enters HUNT.
- pattern  input  PAT_W  target pattern; MSB is the earliest bit; sampled only when load=1.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled live at each match.
- z  output  1  Mealy match output.
- match_count  output  CNT_W  saturating count of matches since load.
- locked  output  1  high while in LOCKED.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pat_q=0, hist=0, fill=0, match_count=0, so z=0 and locked=0. Takes effect immediately, including mid-stream.
- States: IDLE, HUNT, LOCKED.
- IDLE:
  - x and x_valid are ignored; z=0.
  - load=1 goes to HUNT next edge.
- HUNT:
  - hist is a (PAT_W-1)-bit register of the most recent valid bits.
  - fill counts valid bits held, saturating at PAT_W-1.
  - hit is combinational: x_valid & ~load & (fill==PAT_W-1) & ({hist,x}==pat_q).
  - z = hit, in the same cycle as the final pattern bit. Zero-latency Mealy output.
  - On x_valid without hit: hist <= {hist[PAT_W-3:0],x}; fill increments if not saturated.
  - On hit with overlap=1: hist shifts as above; fill stays PAT_W-1.
  - On hit with overlap=0: fill <= 0; hist contents are don't-care.
  - On hit: match_count increments, saturating at 2^CNT_W-1 with no wrap.
  - If LOCK_N!=0 and the incremented count equals LOCK_N, go to LOCKED on the same edge.
  - x_valid=0: hist, fill and count hold; z=0.
- LOCKED:
  - z=1 and locked=1 continuously; x is ignored; match_count is frozen.
  - Only load or reset leaves this state.
- load, from any state:
  - On the edge: pat_q<=pattern, hist<=0, fill<=0, match_count<=0; go to HUNT.
  - load has priority over a simultaneous x_valid. That sample is discarded and z=0 in that cycle, except in LOCKED, where z stays 1 until the edge.
- locked is a registered state decode; z is combinational from state, x, x_valid and load.
- A pattern change without load has no effect.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (IDLE, HUNT, LOCKED) with a 2-bit encoding;
  - the function computing the fill width, clog2(PAT_W).
- One sub-module, sat_counter: CNT_W-bit counter with synchronous clear, increment enable, saturation, and async active-low reset. Used for match_count.
- Everything else lives in seq_detector_param: state register, hist/fill, compare, z decode.

Test Plan (PAT_W=4 unless stated):
1. Reset and idle: pulse rst_n low, then drive x=1, x_valid=1 for 8 cycles with no load -> z=0, match_count=0, locked=0 throughout.
2. Overlap: load 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 -> z=1 on bits 4 and 7 only; match_count=2.
3. Non-overlap: same load and stream, overlap=0 -> z=1 on bit 4 only; match_count=1.
4. Valid gaps and collisions:
   - Stream 1,0 then x_valid=0 for 3 cycles with x toggling, then 1,1 -> z=1 on the final bit; match_count=1.
   - load asserted together with x_valid on a would-be match -> z=0; count=0.
5. Lock (LOCK_N=3):
   - Stream 1011 three times, overlap=0 -> locked=1 from the edge after the third match; z stays 1 for 10 cycles of arbitrary x; match_count=3.
   - Assert load -> locked=0 and count=0 next cycle.
6. Async reset mid-operation: after load 1011 and stream 1,0,1, drop rst_n between clock edges -> z, locked and match_count go to 0 immediately. After release, stream 1 -> z=0 because the block is back in IDLE.
7. Saturation (CNT_W=2, LOCK_N=0): 5 matches -> match_count sticks at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Holds the FSM state encoding and the fill-counter width helper.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // fill must hold 0..pat_w-1
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count visible one cycle after inc/clr.
// Backpressure: none; inc is a single-cycle strobe.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable PAT_W-bit serial pattern detector with match count and optional lock.
// Latency: z is zero-latency Mealy on the final pattern bit; count/locked update on the next edge.
// Backpressure: none; x is consumed only when x_valid is high, load discards that cycle's sample.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             locked
);

    localparam int HIST_W = PAT_W - 1;
    localparam int FILL_W = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  LOCK_VAL  = CNT_W'(LOCK_N);

    state_t              state_q, state_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                locked_q, locked_d;

    logic [PAT_W-1:0]    window;
    logic [HIST_W-1:0]   hist_shift;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic                hit;
    logic                lock_hit;

    // The newest bit joins the held history to form the candidate window.
    assign window     = {hist_q, x};
    assign hist_shift = window[HIST_W-1:0];
    assign cnt_next   = cnt + CNT_W'(1);

    assign hit = (state_q == HUNT) && x_valid && !load &&
                 (fill_q == FILL_FULL) && (window == pat_q);

    // Lock on the match that brings the count to LOCK_N; a saturated count never re-triggers.
    assign lock_hit = (LOCK_N != 0) && hit && (cnt != CNT_MAX) && (cnt_next == LOCK_VAL);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (load) begin
            pat_d   = pattern;
            hist_d  = '0;
            fill_d  = '0;
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT: begin
                    if (x_valid) begin
                        hist_d = hist_shift;
                        if (hit) begin
                            if (!overlap) begin
                                fill_d = '0;
                            end
                            if (lock_hit) begin
                                state_d = LOCKED;
                            end
                        end else if (fill_q != FILL_FULL) begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            hist_q   <= '0;
            fill_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            locked_q <= locked_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (hit),
        .cnt   (cnt)
    );

    assign z           = (state_q == LOCKED) || hit;
    assign match_count = cnt;
    assign locked      = locked_q;

endmodule
